// File: rtl/bist_march_ctrl_pkg.sv
// Shared definitions for the 256x4 SRAM BIST march controller: widths, sequence-word
// field offsets, FSM encoding and data backgrounds. Optional error counter: BIST_ERR_COUNT_EN.
package bist_march_ctrl_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 4;
    localparam int PAT_W     = 2;
    localparam int CNT_W     = 9;
    localparam int SEQ_W     = PAT_W + 1 + ADDR_W;
    localparam int PHASE_BIT = ADDR_W;
    localparam int PAT_LSB   = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [3:0] BG_ZERO = 4'h0;
    localparam logic [3:0] BG_ONE  = 4'hF;
    localparam logic [3:0] BG_CHK  = 4'h5;
    localparam logic [3:0] BG_ICHK = 4'hA;

    // Nibble pattern replicated (or truncated) to the SRAM data width.
    function automatic logic [DATA_W-1:0] background(input logic [PAT_W-1:0] pat);
        logic [3:0]        nib;
        logic [DATA_W-1:0] bits;
        case (pat)
            2'd0:    nib = BG_ZERO;
            2'd1:    nib = BG_ONE;
            2'd2:    nib = BG_CHK;
            default: nib = BG_ICHK;
        endcase
        bits = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bits[i] = nib[i[1:0]];
        end
        return bits;
    endfunction

endpackage

// File: rtl/bist_march_ctrl_compare.sv
// Read-compare stage: one-deep pipe of issued reads, sticky fail flag, first-failure
// capture and, with BIST_ERR_COUNT_EN, a saturating mismatch counter.
module bist_compare
    import bist_march_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cmd_ce,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              fail,
`ifdef BIST_ERR_COUNT_EN
    output logic [CNT_W-1:0]  err_count,
`endif
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act
);

    logic              pipe_v;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_exp;
    logic              mismatch;

    // Read data returns the cycle after the strobe, so compare against the piped command.
    assign mismatch = pipe_v && (rd_data != pipe_exp);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pipe_v    <= 1'b0;
            pipe_addr <= '0;
            pipe_exp  <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else begin
            pipe_v    <= cmd_ce && !cmd_we;
            pipe_addr <= cmd_addr;
            pipe_exp  <= cmd_data;
            if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= pipe_addr;
                    fail_exp  <= pipe_exp;
                    fail_act  <= rd_data;
                end
            end
        end
    end

`ifdef BIST_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count <= '0;
        end else if (mismatch && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/bist_march_ctrl.sv
// Sequencing stage of the SRAM BIST: steps the sequence counter, drives the SRAM port
// and reports pass/fail with first-failure capture. Optional counter: BIST_ERR_COUNT_EN.
module bist_march_ctrl
    import bist_march_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEQ_W-1:0]  seq_in,
    input  logic              seq_cout,
    output logic              seq_rst,
    output logic              seq_cen,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
`ifdef BIST_ERR_COUNT_EN
    output logic [CNT_W-1:0]  err_count,
`endif
    output state_e            dbg_state
);

    state_e state;
    logic   drain_cnt;
    logic   fail;
    logic   clr;

    assign clr       = (state == S_CLR);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
            seq_rst   <= 1'b0;
            seq_cen   <= 1'b0;
            sram_ce   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_CLR;
                        seq_rst <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                S_CLR: begin
                    state   <= S_RUN;
                    seq_rst <= 1'b0;
                    seq_cen <= 1'b1;
                end
                S_RUN: begin
                    if (seq_cout) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                        seq_cen   <= 1'b0;
                        sram_ce   <= 1'b0;
                        sram_we   <= 1'b0;
                    end else begin
                        seq_cen   <= 1'b1;
                        sram_ce   <= 1'b1;
                        sram_we   <= seq_in[PHASE_BIT];
                        sram_addr <= seq_in[ADDR_W-1:0];
                        sram_din  <= background(seq_in[PAT_LSB +: PAT_W]);
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the final read return and be compared before pass is taken.
                    if (drain_cnt) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !fail;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    bist_compare u_compare (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .cmd_ce    (sram_ce),
        .cmd_we    (sram_we),
        .cmd_addr  (sram_addr),
        .cmd_data  (sram_din),
        .rd_data   (sram_dout),
        .fail      (fail),
`ifdef BIST_ERR_COUNT_EN
        .err_count (err_count),
`endif
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act)
    );

endmodule

// File: doc/bist_march_ctrl.md
# bist_march_ctrl

Sequencing and compare stage of the 256x4 SRAM BIST, sitting directly downstream of the bit-line/address sequence counter. On a start pulse it clears and steps that counter, decodes each sequence word into an SRAM access (write or read, address, data background), compares read data against expected one cycle after the read, and records pass/fail plus the first failing access. It is the only block that drives the SRAM port in test mode.

## Interface
- ADDR_W, 8, SRAM address width (256 words)
- DATA_W, 4, SRAM data width
- PAT_W, 2, data-background select field width in the sequence word
- CNT_W, 9, error counter width (only with BIST_ERR_COUNT_EN)
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a test (honoured in IDLE and DONE)
- seq_in  in  PAT_W+1+ADDR_W  sequence word: [ADDR_W-1:0] address, [ADDR_W] phase (1=write, 0=read), [top PAT_W] pattern
- seq_cout  in  1  sequence exhausted
- seq_rst  out  1  clears the sequence counter
- seq_cen  out  1  advances the sequence counter
- sram_ce, sram_we  out  1 each  access strobe, write enable
- sram_addr  out  ADDR_W; sram_din  out  DATA_W
- sram_dout  in  DATA_W  read data, valid the cycle after a read strobe
- busy, done, pass  out  1 each  status
- fail_addr  out  ADDR_W; fail_exp, fail_act  out  DATA_W  first-failure capture
- err_count  out  CNT_W  (only with BIST_ERR_COUNT_EN)

## Operation
- FSM: IDLE -> CLR (start) -> RUN -> DRAIN -> DONE; DONE -> CLR on start; rst from any state -> IDLE.
- CLR: seq_rst=1 one cycle; clears pass/fail capture and err_count.
- RUN: seq_cen=1 while seq_cout=0; each cycle registers seq_in into sram_addr/we/din with sram_ce=1. On seq_cout=1: seq_cen=0, sram_ce=0, go DRAIN.
- Backgrounds: pattern 0 -> 4'h0, 1 -> 4'hF, 2 -> 4'h5, 3 -> 4'hA (replicated/truncated to DATA_W). Read phase expects same background.
- Compare pipe: each issued read registers {addr, expected, valid}; next cycle compares sram_dout. Mismatch sets sticky fail; first mismatch only loads fail_addr/exp/act.
- DRAIN: exactly 2 cycles so last compare completes; then DONE: done=1, pass=~fail, busy=0, held until start or rst.
- start ignored in CLR/RUN/DRAIN.
- Reset values: all outputs 0, state IDLE.

## Timing
- Edge E0 samples start -> seq_rst high next cycle; E1 counter cleared, enter RUN.
- SRAM command lags its sequence word by 1 cycle; compare result lags command by 2 edges.
- Default params (2048 words): seq_cout seen at E2050, done=1 after E2052.
- rst mid-RUN: next edge SRAM strobes 0, captures cleared, done=0; counter is re-cleared by the next CLR.
- Mismatch on same cycle as seq_cout/DRAIN still recorded.

## Configuration
- BIST_ERR_COUNT_EN defined: err_count port present; increments per mismatch, saturates at all-ones, cleared in CLR and rst.
- Undefined: port and counter absent; fail/first-capture behaviour unchanged.

## Structure
- Shared package/header: ADDR_W, DATA_W, PAT_W, sequence-word field offsets, state encoding, background constants.
- One sub-module natural: bist_compare (read pipeline register, comparator, sticky fail, first-fail capture, optional counter).

## Test plan
- Clean SRAM model, default params: start at E0 -> done=1, pass=1 after E2052; fail_addr=0; 1024 writes and 1024 reads observed.
- Inject stuck bit: read of 0x3C in pattern 2 returns 4'h4 -> pass=0, fail_addr=8'h3C, fail_exp=4'h5, fail_act=4'h4, err_count=1.
- Two faults (0x10 pattern 1, 0xFF pattern 3) -> capture holds 0x10/4'hF, err_count=2.
- rst asserted mid-RUN (cycle 500) -> all outputs 0 next edge; new start gives full clean run, pass=1.
- start pulsed during RUN -> no restart, done timing unchanged; start in DONE -> new run, done drops, captures cleared.
- BIST_ERR_COUNT_EN with all 1024 reads failing, CNT_W=9 -> err_count saturates at 511.
